snd_tone_unit: RTL
==================

# snd_tone_unit

Four-channel square-wave tone generator that consumes the CPU's sound write port (`snd_wen`, `w_param`, `w_index`, `w_val`) and drives a mixed amplitude sample plus a 1-bit PWM audio output. It sits directly downstream of the c16 core. The core writes per-channel period, volume, duration and control registers; this block runs the oscillators and note timers autonomously.

## Interface
- `TICK_DIV`, default 50000: clk cycles per duration tick (1 ms at 50 MHz); legal range 2..65535.
- `clk`, input, 1: system clock; all state changes on its rising edge.
- `resetn`, input, 1: asynchronous, active-low reset.
- `snd_wen`, input, 1: write strobe; one write per high cycle.
- `w_param`, input, 2: register select. 0 = period, 1 = volume, 2 = duration, 3 = control.
- `w_index`, input, 11: channel number. Only values 0..3 are accepted.
- `w_val`, input, 16: write data.
- `sample`, output, 6: registered mix of the four channel amplitudes, 0..60.
- `pwm_out`, output, 1: PWM encoding of `sample`.
- `busy`, output, 4: bit n is high while channel n is PLAYING or HOLD.

## Operation
- Writes: a write is accepted when `snd_wen` is high and `w_index < 4`. Writes with `w_index >= 4` are ignored with no side effects.
- Per-channel registers. All reset to 0.
  - period[15:0] = half-period in clk cycles.
  - vol[3:0] = `w_val[3:0]`.
  - dur[15:0] = remaining ticks.
  - phase = 1-bit oscillator output.
  - cnt[15:0] = oscillator counter.
- Writing period loads period and clears cnt. phase is unchanged.
- Writing control:
  - `w_val[0]` = enable.
  - `w_val[1]` = phase reset: clears phase and cnt in the same cycle.
- Channel FSM states: IDLE, PLAYING, HOLD.
  - IDLE -> PLAYING: control write with enable=1 while dur != 0.
  - IDLE -> HOLD: control write with enable=1 while dur == 0.
  - Any state -> IDLE: control write with enable=0.
  - PLAYING -> IDLE: dur decrements from 1 to 0 on a tick. phase is cleared on that transition.
  - Writing dur in PLAYING or HOLD loads the new value without changing state. Writing 0 in PLAYING is honoured at the next tick, which returns the channel to IDLE.
- Oscillator, active only in PLAYING or HOLD with period != 0:
  - cnt increments every cycle.
  - When cnt == period-1: cnt <= 0 and phase toggles.
  - With period == 0, phase is held at 0.
  - In IDLE, cnt and phase hold.
- Tick: one global counter 0..TICK_DIV-1 runs continuously from reset. It raises a 1-cycle tick when it wraps to 0. dur decrements only in PLAYING on tick cycles.
- Mix: `sample` <= sum over channels of (phase && state != IDLE ? vol : 0). The sum is 6-bit, maximum 60, so it never saturates.
- PWM: a free-running 6-bit counter p steps 0..62 and wraps to 0. `pwm_out` <= (p < `sample`). The duty cycle is sample/63.
- Collisions:
  - A register write takes priority over an expiry or oscillator update to the same field in the same cycle.
  - A control write with enable=1 in the same cycle that dur expires leaves the channel active. It enters PLAYING or HOLD according to the post-write dur.

## Timing
- A write sampled at edge N takes effect in registers at edge N. Its effect on `sample` appears at edge N+1.
- An oscillator toggle or an expiry at edge N is reflected in `sample` at edge N+1, and in `pwm_out` from edge N+2.
- Output period of a channel = 2·period clk cycles.
- Reset: all outputs are 0 and every channel is IDLE while `resetn` is low, independent of clk. The first tick occurs TICK_DIV cycles after release.
- Reset asserted mid-note aborts immediately: `busy` and `sample` drop asynchronously.
- `busy` is combinational from the state registers, so it is valid the cycle after the enabling write.

## Test plan
- Basic tone (TICK_DIV=4): ch0 period=3, vol=15, control=1 with dur=0 -> `busy`=0001; `sample` alternates 15/0 every 3 cycles indefinitely.
- Duration expiry: ch1 period=2, vol=8, dur=3, control=1 -> `busy[1]` is high for 3 ticks (12 cycles ±4 phase), then `busy[1]`=0 and `sample`=0.
- Mix and PWM: all four channels vol=15, period=0 -> `sample`=0. Then period=1 with synchronized phase-reset writes -> `sample` toggles 60/0; `pwm_out` is high for 60 of every 63 cycles while `sample`=60.
- Invalid index and collision: a write with `w_index`=4 changes nothing. A control write with enable=1 issued on the same cycle as dur expiry keeps the channel busy (HOLD).
- Retune: a period write mid-tone clears cnt, so the next toggle occurs exactly period cycles later. A control write with `w_val`=3 clears phase and cnt immediately.
- Async reset mid-note: drop `resetn` between clock edges -> `sample`, `pwm_out` and `busy` go to 0 before the next edge; after release, registers read back as silent.

Source files
------------

// File: rtl/snd_tone_unit.sv
`timescale 1ns/1ps
// snd_tone_unit: four-channel square-wave tone generator fed by the c16
// sound write port, producing a mixed amplitude sample and a PWM bit.
module snd_tone_unit #(
    parameter int TICK_DIV = 50000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        snd_wen,
    input  logic [1:0]  w_param,
    input  logic [10:0] w_index,
    input  logic [15:0] w_val,
    output logic [5:0]  sample,
    output logic        pwm_out,
    output logic [3:0]  busy
);

    typedef enum logic [1:0] {
        IDLE,
        PLAYING,
        HOLD
    } ch_state_t;

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
    localparam logic [5:0]  PWM_LAST  = 6'd62;

    ch_state_t   state   [4];
    ch_state_t   state_n [4];
    logic [15:0] period  [4];
    logic [15:0] period_n[4];
    logic [15:0] dur     [4];
    logic [15:0] dur_n   [4];
    logic [15:0] cnt     [4];
    logic [15:0] cnt_n   [4];
    logic [3:0]  vol     [4];
    logic [3:0]  vol_n   [4];
    logic [3:0]  phase;
    logic [3:0]  phase_n;

    logic [15:0] tdiv;
    logic        tick;
    logic        wr_ok;
    logic [3:0]  hit;
    logic [3:0]  wr_per;
    logic [3:0]  wr_vol;
    logic [3:0]  wr_dur;
    logic [3:0]  wr_ctl;
    logic [3:0]  active;
    logic [3:0]  expire;
    logic [3:0]  keep;
    logic [5:0]  mix;
    logic [5:0]  pwm_cnt;

    assign tick = (tdiv == TICK_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tdiv <= '0;
        end else if (tick) begin
            tdiv <= '0;
        end else begin
            tdiv <= tdiv + 16'd1;
        end
    end

    assign wr_ok = snd_wen && (w_index < 11'd4);
    assign busy  = active;

    always_comb begin
        hit    = '0;
        wr_per = '0;
        wr_vol = '0;
        wr_dur = '0;
        wr_ctl = '0;
        active = '0;
        expire = '0;
        keep   = '0;
        for (int n = 0; n < 4; n++) begin
            hit[n]    = wr_ok && (w_index[1:0] == 2'(n));
            wr_per[n] = hit[n] && (w_param == 2'd0);
            wr_vol[n] = hit[n] && (w_param == 2'd1);
            wr_dur[n] = hit[n] && (w_param == 2'd2);
            wr_ctl[n] = hit[n] && (w_param == 2'd3);
            active[n] = (state[n] != IDLE);
            // a same-cycle dur write overrides the pending expiry
            expire[n] = (state[n] == PLAYING) && tick
                        && (dur[n] <= 16'd1) && !wr_dur[n];
            keep[n]   = wr_ctl[n] && w_val[0];
        end
    end

    always_comb begin
        phase_n = phase;
        for (int n = 0; n < 4; n++) begin
            period_n[n] = period[n];
            dur_n[n]    = dur[n];
            cnt_n[n]    = cnt[n];
            vol_n[n]    = vol[n];

            if (active[n]) begin
                if (period[n] == 16'd0) begin
                    phase_n[n] = 1'b0;
                end else if (cnt[n] == period[n] - 16'd1) begin
                    cnt_n[n]   = '0;
                    phase_n[n] = ~phase[n];
                end else begin
                    cnt_n[n] = cnt[n] + 16'd1;
                end
            end

            if (wr_dur[n]) begin
                dur_n[n] = w_val;
            end else if ((state[n] == PLAYING) && tick
                         && (dur[n] != 16'd0)) begin
                dur_n[n] = dur[n] - 16'd1;
            end

            if (wr_vol[n]) begin
                vol_n[n] = w_val[3:0];
            end

            if (wr_per[n]) begin
                period_n[n] = w_val;
                cnt_n[n]    = '0;
                phase_n[n]  = phase[n];
            end

            if (expire[n] && !keep[n]) begin
                phase_n[n] = 1'b0;
            end

            if (wr_ctl[n] && w_val[1]) begin
                phase_n[n] = 1'b0;
                cnt_n[n]   = '0;
            end
        end
    end

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            state_n[n] = state[n];
            unique case (1'b1)
                wr_ctl[n] && !w_val[0]: begin
                    state_n[n] = IDLE;
                end
                keep[n] && (!active[n] || expire[n]): begin
                    state_n[n] = (dur_n[n] != 16'd0) ? PLAYING : HOLD;
                end
                expire[n] && !wr_ctl[n]: begin
                    state_n[n] = IDLE;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            phase <= '0;
            for (int n = 0; n < 4; n++) begin
                state[n]  <= IDLE;
                period[n] <= '0;
                dur[n]    <= '0;
                cnt[n]    <= '0;
                vol[n]    <= '0;
            end
        end else begin
            phase <= phase_n;
            for (int n = 0; n < 4; n++) begin
                state[n]  <= state_n[n];
                period[n] <= period_n[n];
                dur[n]    <= dur_n[n];
                cnt[n]    <= cnt_n[n];
                vol[n]    <= vol_n[n];
            end
        end
    end

    always_comb begin
        mix = '0;
        for (int n = 0; n < 4; n++) begin
            if (active[n] && phase[n]) begin
                mix = mix + 6'(vol[n]);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sample  <= '0;
            pwm_cnt <= '0;
            pwm_out <= 1'b0;
        end else begin
            sample  <= mix;
            pwm_cnt <= (pwm_cnt == PWM_LAST) ? 6'd0 : pwm_cnt + 6'd1;
            pwm_out <= (pwm_cnt < sample);
        end
    end

endmodule
